// File: rtl/agc.sv
// Three-stage VGA automatic gain control: ramps the total gain code until overload, then holds it.
// Optional internal magnitude detector enabled by defining AGC_INT_DETECT_EN.
module agc #(
    parameter int SETTLE_CYCLES = 2,
    parameter int REACQ_CYCLES  = 512,
    parameter int OVL_THRESH    = 24576,
    parameter int GAIN_MAX      = 39
) (
    input  logic               clk,
    input  logic               RESETn,
    input  logic signed [15:0] amplified_signal,
    input  logic               overload,
    input  logic               ext_or_int,
    output logic [4:0]         vga1_control,
    output logic [3:0]         vga2_control,
    output logic [3:0]         vga3_control,
    output logic [5:0]         gain_array_out,
    output logic               done_out
);

    typedef enum logic [1:0] {SETTLE, EVAL, LOCKED} state_t;

    localparam int CNT_MAX = (REACQ_CYCLES > SETTLE_CYCLES) ? REACQ_CYCLES : SETTLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] REACQ_LAST  = CW'(REACQ_CYCLES - 1);
    localparam logic [5:0]    G_MAX       = 6'(GAIN_MAX);

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [5:0]      gain_next;
    logic            ovl;

    // Stage split saturates 15/12/12, so the sum equals G for any G up to 39.
    function automatic logic [4:0] split1(input logic [5:0] g);
        return (g >= 6'd15) ? 5'd15 : g[4:0];
    endfunction

    function automatic logic [3:0] split2(input logic [5:0] g);
        if (g <= 6'd15)
            return 4'd0;
        else if (g >= 6'd27)
            return 4'd12;
        else
            return 4'(g - 6'd15);
    endfunction

    function automatic logic [3:0] split3(input logic [5:0] g);
        if (g <= 6'd27)
            return 4'd0;
        else if (g >= 6'd39)
            return 4'd12;
        else
            return 4'(g - 6'd27);
    endfunction

    assign gain_next = gain_array_out + 6'd1;

`ifdef AGC_INT_DETECT_EN
    localparam logic [15:0] THRESH = 16'(OVL_THRESH);

    logic        hit_reg;
    logic [15:0] mag;

    // Magnitude with -32768 saturated so it fits the positive range.
    always_comb begin
        if (amplified_signal == 16'sh8000)
            mag = 16'h7FFF;
        else if (amplified_signal[15])
            mag = 16'(-amplified_signal);
        else
            mag = amplified_signal;
    end

    assign ovl = ext_or_int ? overload : hit_reg;
`else
    logic unused_inputs;
    assign unused_inputs = ^{ext_or_int, amplified_signal};
    assign ovl = overload;
`endif

    always_ff @(posedge clk or posedge RESETn) begin
        if (RESETn) begin
            state_reg      <= SETTLE;
            cnt_reg        <= '0;
            gain_array_out <= '0;
            vga1_control   <= '0;
            vga2_control   <= '0;
            vga3_control   <= '0;
            done_out       <= 1'b0;
`ifdef AGC_INT_DETECT_EN
            hit_reg        <= 1'b0;
`endif
        end else begin
            case (state_reg)
                SETTLE: begin
`ifdef AGC_INT_DETECT_EN
                    if (mag >= THRESH)
                        hit_reg <= 1'b1;
`endif
                    if (cnt_reg == SETTLE_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= EVAL;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                EVAL: begin
                    cnt_reg <= '0;
                    if (ovl || gain_array_out >= G_MAX) begin
                        state_reg <= LOCKED;
                        done_out  <= 1'b1;
                    end else begin
                        gain_array_out <= gain_next;
                        vga1_control   <= split1(gain_next);
                        vga2_control   <= split2(gain_next);
                        vga3_control   <= split3(gain_next);
                        state_reg      <= SETTLE;
`ifdef AGC_INT_DETECT_EN
                        hit_reg        <= 1'b0;
`endif
                    end
                end
                LOCKED: begin
                    if (cnt_reg == REACQ_LAST) begin
                        cnt_reg        <= '0;
                        gain_array_out <= '0;
                        vga1_control   <= '0;
                        vga2_control   <= '0;
                        vga3_control   <= '0;
                        done_out       <= 1'b0;
                        state_reg      <= SETTLE;
`ifdef AGC_INT_DETECT_EN
                        hit_reg        <= 1'b0;
`endif
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= SETTLE;
                    cnt_reg   <= '0;
                    done_out  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_agc.sv
// Randomised and directed bench for agc, checked every cycle against a step/lock timeline model.
// Internal-detector scenarios run only when AGC_INT_DETECT_EN is defined.
module tb_agc;

    localparam int SC = 2;
    localparam int RC = 64;
    localparam int TH = 24576;
    localparam int GM = 39;

    logic               clk = 1'b0;
    logic               RESETn = 1'b1;
    logic signed [15:0] amplified_signal = '0;
    logic               overload;
    logic               ext_or_int = 1'b1;
    logic [4:0]         vga1_control;
    logic [3:0]         vga2_control;
    logic [3:0]         vga3_control;
    logic [5:0]         gain_array_out;
    logic               done_out;

    int  thr = GM;
    bit  use_thr = 1'b1;
    bit  rnd_ovl = 1'b0;
    int  n_checks = 0;
    int  n_pass = 0;

    // Reference model: position within the current gain step, or time spent locked.
    int  m_g = 0;
    int  m_cnt = 0;
    bit  m_locked = 1'b0;
    bit  m_hit = 1'b0;

    agc #(
        .SETTLE_CYCLES(SC),
        .REACQ_CYCLES (RC),
        .OVL_THRESH   (TH),
        .GAIN_MAX     (GM)
    ) dut (
        .clk             (clk),
        .RESETn          (RESETn),
        .amplified_signal(amplified_signal),
        .overload        (overload),
        .ext_or_int      (ext_or_int),
        .vga1_control    (vga1_control),
        .vga2_control    (vga2_control),
        .vga3_control    (vga3_control),
        .gain_array_out  (gain_array_out),
        .done_out        (done_out)
    );

    always #5 clk = ~clk;

    assign overload = use_thr ? (int'(gain_array_out) >= thr) : rnd_ovl;

    function automatic int mag(input logic signed [15:0] a);
        int v;
        v = int'(a);
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    function automatic int clip(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    always @(posedge clk or posedge RESETn) begin
        bit ext_ovl;
        bit o;
        if (RESETn) begin
            m_g = 0; m_cnt = 0; m_locked = 1'b0; m_hit = 1'b0;
        end else if (m_locked) begin
            m_cnt++;
            if (m_cnt == RC) begin
                m_locked = 1'b0; m_g = 0; m_cnt = 0; m_hit = 1'b0;
            end
        end else if (m_cnt < SC) begin
            if (mag(amplified_signal) >= TH) m_hit = 1'b1;
            m_cnt++;
        end else begin
            ext_ovl = use_thr ? (m_g >= thr) : rnd_ovl;
`ifdef AGC_INT_DETECT_EN
            o = ext_or_int ? ext_ovl : m_hit;
`else
            o = ext_ovl;
`endif
            m_cnt = 0;
            if (o || m_g == GM) begin
                m_locked = 1'b1;
            end else begin
                m_g++;
                m_hit = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    always @(negedge clk) begin
        check("gain", int'(gain_array_out), m_g);
        check("done", int'(done_out), int'(m_locked));
        check("vga1", int'(vga1_control), clip(m_g, 15));
        check("vga2", int'(vga2_control), clip(m_g - 15, 12));
        check("vga3", int'(vga3_control), clip(m_g - 27, 12));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input int g, input int d, input int v1, input int v2, input int v3);
        check({name, "_g"},    int'(gain_array_out), g);
        check({name, "_done"}, int'(done_out), d);
        check({name, "_v1"},   int'(vga1_control), v1);
        check({name, "_v2"},   int'(vga2_control), v2);
        check({name, "_v3"},   int'(vga3_control), v3);
    endtask

    initial begin
        int p;
        step(3);
        lit("reset", 0, 0, 0, 0, 0);
        RESETn = 1'b0;

        // Ramp to full gain: G=39 after 117 clocks, lock on clock 120.
        step(119);
        lit("ramp39_pre", 39, 0, 15, 12, 12);
        step(1);
        lit("lock39", 39, 1, 15, 12, 12);

        thr = 21;
        step(RC - 1);
        lit("hold39", 39, 1, 15, 12, 12);
        step(1);
        lit("reacq", 0, 0, 0, 0, 0);
        step(65);
        lit("ramp21_pre", 21, 0, 15, 6, 0);
        step(1);
        lit("lock21", 21, 1, 15, 6, 0);

        thr = 0;
        step(RC);
        lit("tied_reacq", 0, 0, 0, 0, 0);
        step(SC + 1);
        lit("tied_lock", 0, 1, 0, 0, 0);
        step(RC + SC + 1);
        lit("tied_relock", 0, 1, 0, 0, 0);

        thr = GM;
        step(RC);
        step(10 * (SC + 1));
        lit("mid10", 10, 0, 10, 0, 0);
        RESETn = 1'b1;
        #1;
        lit("async_rst", 0, 0, 0, 0, 0);
        step(2);
        RESETn = 1'b0;
        step(SC + 1);
        lit("restart", 1, 0, 1, 0, 0);

`ifdef AGC_INT_DETECT_EN
        ext_or_int = 1'b0;
        RESETn = 1'b1; step(1); RESETn = 1'b0;
        step(7 * (SC + 1));
        amplified_signal = -16'sd24576;
        step(SC + 1);
        lit("int_lock7", 7, 1, 7, 0, 0);
        amplified_signal = 16'sd24575;
        RESETn = 1'b1; step(1); RESETn = 1'b0;
        step(40 * (SC + 1));
        lit("int_lock39", 39, 1, 15, 12, 12);
        amplified_signal = '0;
        ext_or_int = 1'b1;
`endif

        use_thr = 1'b0;
        for (int blk = 0; blk < 8; blk++) begin
            p = (blk % 3 == 0) ? 0 : ((blk % 3 == 1) ? 8 : 64);
            for (int i = 0; i < 500; i++) begin
                rnd_ovl = (p != 0) && ($urandom_range(p - 1) == 0);
                ext_or_int = 1'($urandom_range(1));
                case ($urandom_range(5))
                    0: amplified_signal = 16'sh8000;
                    1: amplified_signal = 16'(TH);
                    2: amplified_signal = 16'(TH - 1);
                    3: amplified_signal = 16'(-TH);
                    default: amplified_signal = 16'($urandom_range(65535));
                endcase
                RESETn = ($urandom_range(599) == 0);
                step(1);
            end
        end
        RESETn = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/agc.md
AGC -- requirements
Module: agc

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: clocks gain is held before each overload evaluation.
REQ-002 SHALL have parameter REACQ_CYCLES, default 512: clocks spent in LOCKED before re-acquisition.
REQ-003 SHALL have parameter OVL_THRESH, default 24576: internal-detector magnitude threshold.
REQ-004 SHALL have parameter GAIN_MAX, default 39: maximum total gain code.
REQ-005 SHALL have one clock and an asynchronous active-high reset (RESETn asserted = 1).
REQ-006 clk  input  1  rising-edge system clock.
REQ-007 RESETn  input  1  asynchronous active-high reset; the name is kept despite the polarity.
REQ-008 amplified_signal  input  16  signed two's-complement VGA output sample.
REQ-009 overload  input  1  external overload flag: 1 = gain at or above the acceptable level.
REQ-010 ext_or_int  input  1  overload source select: 1 = overload pin, 0 = internal detector.
REQ-011 vga1_control  output  5  stage-1 gain code.
REQ-012 vga2_control  output  4  stage-2 gain code.
REQ-013 vga3_control  output  4  stage-3 gain code.
REQ-014 gain_array_out  output  6  total gain code G, range 0..GAIN_MAX.
REQ-015 done_out  output  1  1 = gain locked.

Function
REQ-016 SHALL implement a three-state FSM: SETTLE, EVAL and LOCKED.
REQ-017 SETTLE SHALL hold G for SETTLE_CYCLES clocks, then go to EVAL.
REQ-018 EVAL, one clock: if ovl=1 or G==GAIN_MAX, go to LOCKED with G unchanged.
REQ-019 EVAL otherwise: G<=G+1 and go to SETTLE.
REQ-020 The locked G SHALL be the smallest code with ovl=1, or GAIN_MAX if none.
REQ-021 LOCKED SHALL hold G and count REACQ_CYCLES clocks, then set G<=0 and go to SETTLE.
REQ-022 ovl changes while in SETTLE or LOCKED SHALL have no effect.
REQ-023 done_out SHALL be 1 exactly while in LOCKED and registered; it SHALL deassert on the clock that leaves LOCKED.
REQ-024 Stage split: vga1=min(G,15); vga2=min(max(G-15,0),12); vga3=min(max(G-27,0),12).
REQ-025 vga1+vga2+vga3 SHALL always equal G.
REQ-026 All outputs SHALL be registered.
REQ-027 G SHALL never exceed GAIN_MAX and SHALL never wrap.
REQ-028 ovl SHALL be sampled only in EVAL: ovl = overload when ext_or_int=1, else the internal flag (REQ-032).

Reset
REQ-029 While RESETn=1: G=0, all vga controls=0, done_out=0, state=SETTLE, all counters=0.
REQ-030 A reset asserted mid-acquisition or in LOCKED SHALL abort immediately, with no completion pulse.
REQ-031 After reset release, the first EVAL SHALL occur SETTLE_CYCLES clocks later.

Configuration
REQ-032 With AGC_INT_DETECT_EN defined: a registered internal flag SHALL be set when |amplified_signal| >= OVL_THRESH during the current SETTLE window.
REQ-033 With AGC_INT_DETECT_EN defined: the internal flag SHALL clear on entry to SETTLE.
REQ-034 With AGC_INT_DETECT_EN defined: |-32768| SHALL saturate to 32767.
REQ-035 Without AGC_INT_DETECT_EN: ovl = overload always; ext_or_int and amplified_signal are ignored and no detector logic exists.

Verification
REQ-036 ext_or_int=1, overload=(G>=39), pulse reset -> G ramps 0..39, one step per SETTLE_CYCLES+1 clocks; locks at 39 with vga 15/12/12, done_out=1.
REQ-037 From the lock at 39, switch to overload=(G>=21) -> on re-acquisition done_out=0 and G=0, then ramp; locks at 21 with vga 15/6/0, done_out=1.
REQ-038 overload tied 1 -> lock at G=0 after the first EVAL; re-acquisition every REACQ_CYCLES clocks returns to G=0.
REQ-039 Assert reset at G=10 mid-ramp -> all outputs 0 asynchronously; after release, ramp restarts from 0.
REQ-040 AGC_INT_DETECT_EN defined, ext_or_int=0, amplified_signal=-24576 from G=7 onward -> lock at G=7.
REQ-041 Same setup with amplified_signal=24575 -> no overload; lock at 39.
